mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_req_slot.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and widths for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic REQ_MCU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

endpackage

// File: rtl/mem_req_slot.sv
// rtl/mem_req_slot.sv - one-entry pending request slot with lost-request detection
module mem_req_slot
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_grant,
  output logic              o_valid,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_overrun
);

  logic              r_pend;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // A stored entry is older than a same-cycle pulse, so it is presented first.
  assign o_valid   = r_pend | i_req;
  assign o_we      = r_pend ? r_we    : i_we;
  assign o_addr    = r_pend ? r_addr  : i_addr;
  assign o_wdata   = r_pend ? r_wdata : i_wdata;
  assign o_overrun = i_req & r_pend & ~i_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_req && (r_pend || !i_grant)) begin
      r_pend  <= 1'b1;
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (i_grant) begin
      r_pend  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates MCU and SD DMA accesses onto a shared memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ACC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mcu_rrq,
  input  logic              mcu_wrq,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [DATA_W-1:0] mcu_wdata,
  output logic              mcu_rq_rdy,
  output logic [DATA_W-1:0] mcu_rdata,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  input  logic              snes_active,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              overrun
);

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_gnt_id;
  acc_t              r_acc;
  logic [DATA_W-1:0] r_mcu_rdata;
  logic              r_overrun;

  logic              w_mcu_valid, w_mcu_we, w_mcu_ovr;
  logic [ADDR_W-1:0] w_mcu_addr;
  logic [DATA_W-1:0] w_mcu_wdata;
  logic              w_dma_valid, w_dma_we, w_dma_ovr;
  logic [ADDR_W-1:0] w_dma_addr;
  logic [DATA_W-1:0] w_dma_wdata;
  logic              w_arb_open, w_gnt_dma, w_gnt_mcu;

  // A simultaneous read+write from the MCU collapses to the write.
  mem_req_slot u_mcu_slot (
    .clk       (clk),
    .rst       (rst),
    .i_req     (mcu_rrq | mcu_wrq),
    .i_we      (mcu_wrq),
    .i_addr    (mcu_addr),
    .i_wdata   (mcu_wdata),
    .i_grant   (w_gnt_mcu),
    .o_valid   (w_mcu_valid),
    .o_we      (w_mcu_we),
    .o_addr    (w_mcu_addr),
    .o_wdata   (w_mcu_wdata),
    .o_overrun (w_mcu_ovr)
  );

  mem_req_slot u_dma_slot (
    .clk       (clk),
    .rst       (rst),
    .i_req     (dma_we),
    .i_we      (1'b1),
    .i_addr    (dma_addr),
    .i_wdata   (dma_wdata),
    .i_grant   (w_gnt_dma),
    .o_valid   (w_dma_valid),
    .o_we      (w_dma_we),
    .o_addr    (w_dma_addr),
    .o_wdata   (w_dma_wdata),
    .o_overrun (w_dma_ovr)
  );

  assign w_arb_open = (r_state == ST_IDLE) && !snes_active;
  assign w_gnt_dma  = w_arb_open && w_dma_valid;
  assign w_gnt_mcu  = w_arb_open && !w_dma_valid && w_mcu_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_gnt_id    <= REQ_MCU;
      r_acc       <= '0;
      r_mcu_rdata <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= r_overrun | w_mcu_ovr | w_dma_ovr | (mcu_rrq & mcu_wrq);
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_dma || w_gnt_mcu) begin
            r_state  <= ST_ACCESS;
            r_cnt    <= CNT_LOAD;
            r_gnt_id <= w_gnt_dma ? REQ_DMA : REQ_MCU;
            r_acc    <= w_gnt_dma ? acc_t'{w_dma_we, w_dma_addr, w_dma_wdata}
                                  : acc_t'{w_mcu_we, w_mcu_addr, w_mcu_wdata};
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
            if ((r_gnt_id == REQ_MCU) && !r_acc.we) begin
              r_mcu_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req    = (r_state == ST_ACCESS);
  assign mem_we     = r_acc.we;
  assign mem_addr   = r_acc.addr;
  assign mem_wdata  = r_acc.wdata;
  assign mcu_rq_rdy = (r_state == ST_DONE) && (r_gnt_id == REQ_MCU);
  assign dma_ack    = (r_state == ST_DONE) && (r_gnt_id == REQ_DMA);
  assign mcu_rdata  = r_mcu_rdata;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for the memory port arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ACC = 4;

  typedef struct {
    logic        is_dma;
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mcu_rrq, mcu_wrq, dma_we, snes_active;
  logic [23:0] mcu_addr, dma_addr;
  logic [7:0]  mcu_wdata, dma_wdata, mem_rdata;
  logic        mcu_rq_rdy, dma_ack, mem_req, mem_we, overrun;
  logic [7:0]  mcu_rdata, mem_wdata;
  logic [23:0] mem_addr;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          run_len = 0;
  logic        run_we;
  logic [23:0] run_addr;
  logic [7:0]  run_wdata;
  int          t, t0, t2;

  mem_port_arbiter #(.ACC_CYCLES(ACC)) dut (
    .clk(clk), .rst(rst),
    .mcu_rrq(mcu_rrq), .mcu_wrq(mcu_wrq), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .mcu_rq_rdy(mcu_rq_rdy), .mcu_rdata(mcu_rdata),
    .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .snes_active(snes_active),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic is_dma, input logic we, input logic [23:0] a,
                      input logic [7:0] d, input logic [7:0] rd, input int done);
    exp_t x;
    x.is_dma = is_dma; x.we = we; x.addr = a; x.wdata = d; x.rdata = rd; x.done_cyc = done;
    sb.push_back(x);
  endtask

  task automatic mcu_req(input logic rd, input logic wr, input logic [23:0] a, input logic [7:0] d);
    mcu_rrq = rd; mcu_wrq = wr; mcu_addr = a; mcu_wdata = d;
    tick();
    mcu_rrq = 1'b0; mcu_wrq = 1'b0;
  endtask

  task automatic dma_req(input logic [23:0] a, input logic [7:0] d);
    dma_we = 1'b1; dma_addr = a; dma_wdata = d;
    tick();
    dma_we = 1'b0;
  endtask

  // Observes every memory access and checks each completion against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      if (mem_req) begin
        if (run_len == 0) begin
          run_we = mem_we; run_addr = mem_addr; run_wdata = mem_wdata;
        end else begin
          chk("access_stable", {31'd0, mem_we, mem_addr, mem_wdata}, {31'd0, run_we, run_addr, run_wdata});
        end
        run_len++;
      end
      if (mcu_rq_rdy || dma_ack) begin
        chk("done_mem_req_low", mem_req, 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", {dma_ack, mcu_rq_rdy}, 0);
        end else begin
          e = sb.pop_front();
          chk("done_who", {dma_ack, mcu_rq_rdy}, e.is_dma ? 2'b10 : 2'b01);
          chk("done_cycle", cyc, e.done_cyc);
          chk("access_len", run_len, ACC);
          chk("access_addr", run_addr, e.addr);
          chk("access_we", run_we, e.we);
          if (e.we) chk("access_wdata", run_wdata, e.wdata);
          else if (!e.is_dma) chk("mcu_rdata", mcu_rdata, e.rdata);
        end
        run_len = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; mcu_rrq = 0; mcu_wrq = 0; dma_we = 0; snes_active = 0;
    mcu_addr = 0; mcu_wdata = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
    tick(); tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pulses", {mcu_rq_rdy, dma_ack}, 0);
    chk("rst_mcu_rdata", mcu_rdata, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick();

    // MCU read, no contention
    t = cyc;
    mem_rdata = 8'hA5;
    push(0, 0, 24'h123456, 8'h00, 8'hA5, t + ACC + 1);
    mcu_req(1, 0, 24'h123456, 8'h00);
    chk("read_mem_req_t1", mem_req, 1);
    chk("read_mem_addr_t1", mem_addr, 24'h123456);
    wait_to(t + 8);
    chk("read_rdata_hold", mcu_rdata, 8'hA5);

    // DMA and MCU write in the same cycle: DMA first
    t = cyc;
    push(1, 1, 24'h00AA00, 8'h11, 8'h00, t + 5);
    push(0, 1, 24'h0BEEF0, 8'h22, 8'h00, t + 11);
    dma_we = 1; dma_addr = 24'h00AA00; dma_wdata = 8'h11;
    mcu_wrq = 1; mcu_addr = 24'h0BEEF0; mcu_wdata = 8'h22;
    tick();
    dma_we = 0; mcu_wrq = 0;
    wait_to(t + 6);
    chk("contend_idle_gap", mem_req, 0);
    wait_to(t + 14);
    chk("contend_overrun", overrun, 0);

    // SNES owns memory for 10 cycles while an MCU write pends
    t0 = cyc;
    snes_active = 1;
    tick();
    push(0, 1, 24'h345678, 8'h5C, 8'h00, t0 + 15);
    mcu_req(0, 1, 24'h345678, 8'h5C);
    while (cyc < t0 + 10) begin
      chk("snes_blocked", mem_req, 0);
      tick();
    end
    snes_active = 0;
    chk("snes_fall_cycle", mem_req, 0);
    tick();
    chk("snes_grant_next", mem_req, 1);
    wait_to(t0 + 17);

    // pulse in the same cycle its pending slot is granted
    t = cyc;
    push(1, 1, 24'h000200, 8'h44, 8'h00, t + 5);
    dma_req(24'h000200, 8'h44);
    push(0, 1, 24'h0A0A0A, 8'h55, 8'h00, t + 11);
    mcu_req(0, 1, 24'h0A0A0A, 8'h55);
    wait_to(t + 6);
    push(0, 1, 24'h0B0B0B, 8'h66, 8'h00, t + 17);
    mcu_req(0, 1, 24'h0B0B0B, 8'h66);
    wait_to(t + 19);
    chk("regrant_overrun", overrun, 0);

    // snes_active rising mid-access leaves the access intact
    t = cyc;
    push(0, 1, 24'h00C0DE, 8'h77, 8'h00, t + 5);
    mcu_req(0, 1, 24'h00C0DE, 8'h77);
    wait_to(t + 2);
    snes_active = 1;
    tick();
    chk("snes_mid_access", mem_req, 1);
    wait_to(t + 9);
    snes_active = 0;

    // two MCU reads during a DMA access: second wins, overrun set
    t = cyc;
    mem_rdata = 8'h7E;
    push(1, 1, 24'h000100, 8'h33, 8'h00, t + 5);
    push(0, 0, 24'h222222, 8'h00, 8'h7E, t + 11);
    dma_req(24'h000100, 8'h33);
    mcu_req(1, 0, 24'h111111, 8'h00);
    tick();
    chk("ovr_before_second", overrun, 0);
    mcu_req(1, 0, 24'h222222, 8'h00);
    chk("ovr_after_second", overrun, 1);
    wait_to(t + 13);
    chk("ovr_sticky", overrun, 1);

    // reset in the 2nd ACCESS cycle aborts; coincident DMA pulse ignored
    rst = 1;
    tick();
    rst = 0;
    chk("abort_overrun_cleared", overrun, 0);
    t = cyc;
    mcu_req(1, 0, 24'h0ABCDE, 8'h00);
    tick();
    chk("abort_in_access", mem_req, 1);
    rst = 1; dma_we = 1; dma_addr = 24'h0F0F0F; dma_wdata = 8'hEE;
    tick();
    rst = 0; dma_we = 0;
    chk("abort_mem_req_low", mem_req, 0);
    wait_to(t + ACC + 1);
    chk("abort_no_rdy", mcu_rq_rdy, 0);
    wait_to(t + 10);
    chk("abort_idle", mem_req, 0);
    t2 = cyc;
    push(0, 1, 24'h0DDDDD, 8'h88, 8'h00, t2 + 5);
    mcu_req(0, 1, 24'h0DDDDD, 8'h88);
    wait_to(t2 + 7);

    // DMA pulses every 6 cycles
    for (int k = 0; k < 5; k++) begin
      t = cyc;
      push(1, 1, 24'h000300 + 24'(k), 8'(k + 1), 8'h00, t + 5);
      dma_req(24'h000300 + 24'(k), 8'(k + 1));
      wait_to(t + 6);
    end
    chk("dma_stream_overrun", overrun, 0);

    // simultaneous MCU read+write: write taken, overrun set
    t = cyc;
    push(0, 1, 24'h0E0E0E, 8'h99, 8'h00, t + 5);
    mcu_req(1, 1, 24'h0E0E0E, 8'h99);
    chk("rw_overrun", overrun, 1);
    wait_to(t + 7);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
